// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared definitions for the ROM read sequencer.
//   state_t / ST_*   : FSM state encoding (INIT, IDLE, ISSUE, DONE)
//   CE_ACTIVE        : ROM chip-enable asserted level
//   RD_ACTIVE        : ROM read-enable asserted level (active low)
//   *_DEFAULT        : default prescaler and debounce lengths
package rom_seq_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_INIT  = 2'd0;
    localparam state_t ST_IDLE  = 2'd1;
    localparam state_t ST_ISSUE = 2'd2;
    localparam state_t ST_DONE  = 2'd3;
    localparam logic CE_ACTIVE = 1'b1;
    localparam logic RD_ACTIVE = 1'b0;
    localparam int TICK_DIV_DEFAULT        = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces a raw push-button.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : asynchronous button input
//   btn_level  : accepted (debounced) button level
//   btn_rise   : one-cycle pulse when the accepted level goes 0->1
module btn_debounce import rom_seq_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync_a, sync_b;
    logic [CW-1:0] cnt;
    // cnt counts consecutive synchronized samples that disagree with the
    // accepted level; the level flips on the DEBOUNCE_CYCLES-th such sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
        end else begin
            sync_a   <= btn_raw;
            sync_b   <= sync_a;
            btn_rise <= 1'b0;
            if (sync_b != btn_level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level <= sync_b;
                    btn_rise  <= sync_b;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/rom_read_sequencer.sv
// rom_read_sequencer: address/control stage in front of the display ROM.
//   clk, rst_n  : clock, asynchronous active-low reset
//   step_btn    : raw push-button, one step per accepted press (mode=0)
//   mode        : 0 = manual, 1 = auto (prescaler tick)
//   run         : auto-mode enable
//   clear       : return to START_ADDR and re-read
//   address_out : ROM address
//   ce, rd_en   : ROM chip enable (high), read enable (low)
//   data_valid  : ROM data_out holds mem[address_out]
//   busy        : FSM not idle
//   wrap_pulse  : address wrapped END_ADDR -> START_ADDR
module rom_read_sequencer import rom_seq_pkg::*; #(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int START_ADDR      = 0,
    parameter int END_ADDR        = 2**ADDRESS_WIDTH - 1,
    parameter int TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step_btn,
    input  logic                     mode,
    input  logic                     run,
    input  logic                     clear,
    output logic [ADDRESS_WIDTH-1:0] address_out,
    output logic                     ce,
    output logic                     rd_en,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     wrap_pulse
);
    localparam logic [ADDRESS_WIDTH-1:0] FIRST = ADDRESS_WIDTH'(START_ADDR);
    localparam logic [ADDRESS_WIDTH-1:0] LAST  = ADDRESS_WIDTH'(END_ADDR);
    localparam int PW = $clog2(TICK_DIV);
    state_t state;
    logic [PW-1:0] presc;
    logic mode_q, pending_clear, btn_level, btn_rise, tick, step;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(step_btn),
        .btn_level(btn_level),
        .btn_rise(btn_rise)
    );
    assign tick = mode && run && (presc == PW'(TICK_DIV - 1));
    // a rise pulse always coincides with the newly accepted high level
    assign step = mode ? tick : (btn_rise && btn_level);
    // mode_q detects any change of mode so the prescaler restarts from 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode != mode_q)
                presc <= '0;
            else if (mode && run)
                presc <= tick ? '0 : presc + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            address_out   <= FIRST;
            wrap_pulse    <= 1'b0;
            pending_clear <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            case (state)
                ST_INIT:  state <= ST_ISSUE;
                ST_IDLE: begin
                    if (clear || pending_clear) begin
                        address_out   <= FIRST;
                        pending_clear <= 1'b0;
                        state         <= ST_ISSUE;
                    end else if (step) begin
                        address_out <= (address_out == LAST) ? FIRST : address_out + 1'b1;
                        wrap_pulse  <= (address_out == LAST);
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
            // steps and ticks are dropped while busy, clears are remembered
            if (clear && state != ST_IDLE)
                pending_clear <= 1'b1;
        end
    end
    assign ce         = (state == ST_ISSUE) ? CE_ACTIVE : ~CE_ACTIVE;
    assign rd_en      = (state == ST_ISSUE) ? RD_ACTIVE : ~RD_ACTIVE;
    assign data_valid = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_rom_read_sequencer.sv
// tb_rom_read_sequencer: randomized bench against a behavioural model.
module tb_rom_read_sequencer;
    localparam int AW = 8;
    localparam int SA = 0;
    localparam int EA = 3;
    localparam int TD = 4;
    localparam int DB = 2;
    logic clk = 1'b0;
    logic rst_n, step_btn, mode, run, clear;
    logic [AW-1:0] address_out;
    logic ce, rd_en, data_valid, busy, wrap_pulse;
    int n_checks = 0;
    int n_fail = 0;
    int n_wrap_man = 0;
    int n_wrap_auto = 0;
    // model: read countdown (3 = priming pending, 2 = ROM access, 1 = data ready, 0 = idle)
    int  m_addr, m_phase, m_presc;
    bit  m_pend, m_wrap, m_mode_last, m_lvl, m_rise;
    bit  bq[$];
    rom_read_sequencer #(
        .ADDRESS_WIDTH(AW), .START_ADDR(SA), .END_ADDR(EA),
        .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .mode(mode),
        .run(run), .clear(clear), .address_out(address_out), .ce(ce),
        .rd_en(rd_en), .data_valid(data_valid), .busy(busy),
        .wrap_pulse(wrap_pulse)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    task automatic model_reset();
        m_addr = SA;
        m_phase = 3;
        m_presc = 0;
        m_pend = 0;
        m_wrap = 0;
        m_mode_last = 0;
        m_lvl = 0;
        m_rise = 0;
        bq.delete();
        repeat (DB + 2) bq.push_front(1'b0);
    endtask
    // bq[k] holds the button as sampled k+1 edges ago; the debouncer sees it two edges late
    task automatic model_edge();
        bit tick, step, flip;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = mode && run && (m_presc == TD - 1);
        step = mode ? tick : m_rise;
        flip = 1;
        for (int i = 1; i <= DB; i++) if (bq[i] == m_lvl) flip = 0;
        m_rise = flip && !m_lvl;
        if (flip) m_lvl = !m_lvl;
        bq.push_front(step_btn);
        while (bq.size() > DB + 2) void'(bq.pop_back());
        if (mode != m_mode_last) m_presc = 0;
        else if (mode && run) m_presc = (m_presc + 1) % TD;
        m_mode_last = mode;
        m_wrap = 0;
        if (m_phase == 0) begin
            if (clear || m_pend) begin
                m_addr = SA;
                m_pend = 0;
                m_phase = 2;
            end else if (step) begin
                m_wrap = (m_addr == EA);
                m_addr = (m_addr == EA) ? SA : m_addr + 1;
                m_phase = 2;
            end
        end else begin
            if (clear) m_pend = 1;
            m_phase--;
        end
    endtask
    task automatic compare_all(input string tag);
        logic [4:0] exp_ctrl;
        exp_ctrl = {m_phase == 2, m_phase != 2, m_phase == 1, m_phase != 0, m_wrap};
        check({tag, "_addr"}, 32'(address_out), 32'(m_addr));
        check({tag, "_ctrl"}, 32'({ce, rd_en, data_valid, busy, wrap_pulse}), 32'(exp_ctrl));
        if (wrap_pulse && mode) n_wrap_auto++;
        if (wrap_pulse && !mode) n_wrap_man++;
    endtask
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask
    initial begin
        int hold = 0;
        int rst_left = 0;
        rst_n = 1'b0;
        step_btn = 1'b0;
        mode = 1'b0;
        run = 1'b0;
        clear = 1'b0;
        model_reset();
        repeat (3) cycle("reset");
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                step_btn = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            if (c < 1000) mode = 1'b0;
            else if (c < 2000) mode = 1'b1;
            else if ($urandom_range(0, 59) == 0) mode = !mode;
            if ($urandom_range(0, 19) == 0) run = !run;
            clear = ($urandom_range(0, 49) == 0);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst_n = 1'b1;
            end else if (c > 100 && $urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_all("async_rst");
                rst_left = $urandom_range(1, 3);
            end
            cycle("run");
        end
        check("manual_wrap_seen", 32'(n_wrap_man > 0), 32'd1);
        check("auto_wrap_seen", 32'(n_wrap_auto > 0), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
